// File: rtl/branch_prediction_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and counter constants for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        BP_BR   = 2'd0,
        BP_JAL  = 2'd1,
        BP_JALR = 2'd2,
        BP_RET  = 2'd3
    } bp_type_e;

    localparam logic [1:0] PHT_RESET = 2'b01;
    localparam logic [1:0] PHT_MAX   = 2'b11;
    localparam logic [1:0] PHT_MIN   = 2'b00;

    // Tag and target widths depend on instance parameters, so they live in
    // separate arrays next to this per-entry control word.
    typedef struct packed {
        logic     valid;
        bp_type_e btype;
    } btb_entry_t;

    function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == PHT_MAX) ? cnt : cnt + 2'd1;
        else
            return (cnt == PHT_MIN) ? cnt : cnt - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_prediction_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_prediction_unit_if
// Description : Fetch-lookup and EX-update bundle between pipeline and predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_prediction_unit_if
    import bp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int GHR_W = 4
);
    logic [XLEN-1:0]  if_pc_i;
    logic             if_hit_o;
    logic             if_taken_o;
    logic [XLEN-1:0]  if_target_o;
    logic [GHR_W-1:0] if_ghr_o;
    logic             ex_valid_i;
    logic [XLEN-1:0]  ex_pc_i;
    bp_type_e         ex_type_i;
    logic             ex_is_call_i;
    logic             ex_taken_i;
    logic [XLEN-1:0]  ex_target_i;
    logic [GHR_W-1:0] ex_ghr_i;
    logic             flush_i;

    modport master (
        output if_pc_i, ex_valid_i, ex_pc_i, ex_type_i, ex_is_call_i,
               ex_taken_i, ex_target_i, ex_ghr_i, flush_i,
        input  if_hit_o, if_taken_o, if_target_o, if_ghr_o
    );

    modport slave (
        input  if_pc_i, ex_valid_i, ex_pc_i, ex_type_i, ex_is_call_i,
               ex_taken_i, ex_target_i, ex_ghr_i, flush_i,
        output if_hit_o, if_taken_o, if_target_o, if_ghr_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_prediction_unit_ras.sv
`default_nettype none
// ============================================================================
// Module      : bp_ras
// Description : Circular return-address stack; pop-then-push on the same op.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_push,
    input  wire logic            i_pop,
    input  wire logic            i_flush,
    input  wire logic [XLEN-1:0] i_data,
    output logic      [XLEN-1:0] o_top,
    output logic                 o_empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pop_ok;
    logic [PTR_W-1:0] w_ptr_pop;
    logic [PTR_W-1:0] w_ptr_push;
    logic [CNT_W-1:0] w_cnt_pop;

    assign w_pop_ok   = i_pop && (r_cnt != '0);
    assign w_ptr_pop  = r_ptr - PTR_W'(w_pop_ok);
    assign w_cnt_pop  = r_cnt - CNT_W'(w_pop_ok);
    assign w_ptr_push = w_ptr_pop + PTR_W'(1);

    // A push into a full stack wraps onto the oldest slot; count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
        end else if (i_flush) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_stack[w_ptr_push] <= i_data;
            r_ptr               <= w_ptr_push;
            r_cnt               <= (w_cnt_pop == CNT_W'(RAS_DEPTH)) ? w_cnt_pop
                                                                     : w_cnt_pop + CNT_W'(1);
        end else begin
            r_ptr <= w_ptr_pop;
            r_cnt <= w_cnt_pop;
        end
    end

    assign o_top   = r_stack[r_ptr];
    assign o_empty = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/branch_prediction_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_prediction_unit
// Description : Typed BTB + gshare PHT + RAS front-end predictor, EX-updated.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_prediction_unit
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_W       = 4,
    parameter int RAS_DEPTH   = 4
) (
    input wire logic               clk,
    input wire logic               rst,
    branch_prediction_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int PHT_N = 1 << GHR_W;

    btb_entry_t       r_btb_meta [BTB_ENTRIES];
    logic [TAG_W-1:0] r_btb_tag  [BTB_ENTRIES];
    logic [XLEN-1:0]  r_btb_tgt  [BTB_ENTRIES];
    logic [1:0]       r_pht      [PHT_N];
    logic [GHR_W-1:0] r_ghr;

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    logic [GHR_W-1:0] w_if_pht, w_ex_pht;
    btb_entry_t       w_if_ent;
    logic             w_hit;
    logic             w_btb_we;
    logic             w_pht_we;
    logic [XLEN-1:0]  w_ras_top;
    logic             w_ras_empty;
    logic             w_unused_pc;

    assign w_if_idx = bus.if_pc_i[IDX_W+1:2];
    assign w_if_tag = bus.if_pc_i[XLEN-1:IDX_W+2];
    assign w_if_pht = bus.if_pc_i[GHR_W+1:2] ^ r_ghr;
    assign w_ex_idx = bus.ex_pc_i[IDX_W+1:2];
    assign w_ex_tag = bus.ex_pc_i[XLEN-1:IDX_W+2];
    assign w_ex_pht = bus.ex_pc_i[GHR_W+1:2] ^ bus.ex_ghr_i;
    assign w_unused_pc = ^{bus.if_pc_i[1:0], bus.ex_pc_i[1:0]};

    assign w_if_ent = r_btb_meta[w_if_idx];
    assign w_hit    = w_if_ent.valid && (r_btb_tag[w_if_idx] == w_if_tag);

    assign bus.if_hit_o    = w_hit;
    assign bus.if_taken_o  = w_hit && ((w_if_ent.btype != BP_BR) || r_pht[w_if_pht][1]);
    assign bus.if_target_o = ((w_if_ent.btype == BP_RET) && !w_ras_empty) ? w_ras_top
                                                                          : r_btb_tgt[w_if_idx];
    assign bus.if_ghr_o    = r_ghr;

    // Branches only allocate when taken; a flush in the same cycle wins.
    assign w_btb_we = bus.ex_valid_i && !bus.flush_i
                      && ((bus.ex_type_i != BP_BR) || bus.ex_taken_i);
    assign w_pht_we = bus.ex_valid_i && (bus.ex_type_i == BP_BR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_meta[i] <= '{valid: 1'b0, btype: BP_BR};
                r_btb_tag[i]  <= '0;
                r_btb_tgt[i]  <= '0;
            end
        end else if (bus.flush_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) r_btb_meta[i].valid <= 1'b0;
        end else if (w_btb_we) begin
            r_btb_meta[w_ex_idx] <= '{valid: 1'b1, btype: bus.ex_type_i};
            r_btb_tag[w_ex_idx]  <= w_ex_tag;
            r_btb_tgt[w_ex_idx]  <= bus.ex_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= PHT_RESET;
        end else if (w_pht_we) begin
            r_pht[w_ex_pht] <= pht_next(r_pht[w_ex_pht], bus.ex_taken_i);
            r_ghr           <= {r_ghr[GHR_W-2:0], bus.ex_taken_i};
        end
    end

    bp_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.ex_valid_i && bus.ex_is_call_i),
        .i_pop   (bus.ex_valid_i && (bus.ex_type_i == BP_RET)),
        .i_flush (bus.flush_i),
        .i_data  (bus.ex_pc_i + XLEN'(4)),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_prediction_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_prediction_unit
// Description : Directed self-checking bench for branch_prediction_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_prediction_unit;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_prediction_unit_if #(.XLEN(32), .GHR_W(4)) bus ();

    branch_prediction_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .GHR_W       (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One EX update; inputs are applied 1 time unit after a rising edge.
    task automatic upd(input logic [31:0] pc, input bp_type_e t, input logic call,
                       input logic tk, input logic [31:0] tgt, input logic [3:0] g,
                       input logic fl);
        bus.ex_valid_i   = 1'b1;
        bus.ex_pc_i      = pc;
        bus.ex_type_i    = t;
        bus.ex_is_call_i = call;
        bus.ex_taken_i   = tk;
        bus.ex_target_i  = tgt;
        bus.ex_ghr_i     = g;
        bus.flush_i      = fl;
        @(posedge clk);
        #1;
        bus.ex_valid_i   = 1'b0;
        bus.ex_is_call_i = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic lk(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt, input logic ctgt);
        bus.if_pc_i = pc;
        #1;
        chk({tag, ".hit"}, 32'(bus.if_hit_o), 32'(hit));
        chk({tag, ".taken"}, 32'(bus.if_taken_o), 32'(tk));
        if (ctgt) chk({tag, ".target"}, bus.if_target_o, tgt);
    endtask

    initial begin
        bus.if_pc_i      = 32'h100;
        bus.ex_valid_i   = 1'b0;
        bus.ex_pc_i      = '0;
        bus.ex_type_i    = BP_BR;
        bus.ex_is_call_i = 1'b0;
        bus.ex_taken_i   = 1'b0;
        bus.ex_target_i  = '0;
        bus.ex_ghr_i     = '0;
        bus.flush_i      = 1'b0;

        // Reset
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lk("reset", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("reset.ghr", 32'(bus.if_ghr_o), 32'h0);
        rst = 1'b1;

        // Branch training: ghr walks 0->f, then PHT[f] saturates at 3
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'h0, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'h1, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'h3, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'h7, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'hf, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'hf, 1'b0);
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'hf, 1'b0);
        lk("br_sat", 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
        chk("br_sat.ghr", 32'(bus.if_ghr_o), 32'hf);

        // Not-taken: PHT[f] 3->2, ghr -> e; PHT[e] still 1 so lookup not taken
        upd(32'h100, BP_BR, 1'b0, 1'b0, 32'h104, 4'hf, 1'b0);
        lk("br_nt", 32'h100, 1'b1, 1'b0, 32'h80, 1'b1);
        chk("br_nt.ghr", 32'(bus.if_ghr_o), 32'he);

        // Refill ghr to f via branches at 0x13C (PHT 1,2,4,8); PHT[f]=2 taken
        upd(32'h13C, BP_BR, 1'b0, 1'b1, 32'h200, 4'he, 1'b0);
        upd(32'h13C, BP_BR, 1'b0, 1'b1, 32'h200, 4'hd, 1'b0);
        upd(32'h13C, BP_BR, 1'b0, 1'b1, 32'h200, 4'hb, 1'b0);
        upd(32'h13C, BP_BR, 1'b0, 1'b1, 32'h200, 4'h7, 1'b0);
        lk("br_cnt2", 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
        chk("br_cnt2.ghr", 32'(bus.if_ghr_o), 32'hf);

        // RET entry with empty RAS falls back to BTB target
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("ret_empty", 32'h704, 1'b1, 1'b1, 32'h900, 1'b1);

        // Five calls into a 4-deep RAS: oldest (0x204) overwritten
        for (int i = 2; i <= 6; i++)
            upd(32'(i * 256), BP_JAL, 1'b1, 1'b1, 32'h1000, 4'hf, 1'b0);
        lk("ras_top", 32'h704, 1'b1, 1'b1, 32'h604, 1'b1);
        lk("call_alias", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);

        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("pop1", 32'h704, 1'b1, 1'b1, 32'h504, 1'b1);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("pop2", 32'h704, 1'b1, 1'b1, 32'h404, 1'b1);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("pop3", 32'h704, 1'b1, 1'b1, 32'h304, 1'b1);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("pop4", 32'h704, 1'b1, 1'b1, 32'h900, 1'b1);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("pop5", 32'h704, 1'b1, 1'b1, 32'h900, 1'b1);

        // jalr x1,x1: pop then push replaces top, count stays 1
        upd(32'h800, BP_JAL, 1'b1, 1'b1, 32'h1000, 4'hf, 1'b0);
        upd(32'h900, BP_RET, 1'b1, 1'b1, 32'h2000, 4'hf, 1'b0);
        lk("callret", 32'h900, 1'b1, 1'b1, 32'h904, 1'b1);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hf, 1'b0);
        lk("callret_pop", 32'h704, 1'b1, 1'b1, 32'h900, 1'b1);

        // BTB aliasing 0x100 vs 0x140
        upd(32'h100, BP_BR, 1'b0, 1'b1, 32'h80, 4'hf, 1'b0);
        upd(32'h140, BP_JAL, 1'b0, 1'b1, 32'h2000, 4'hf, 1'b0);
        lk("alias_old", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        lk("alias_new", 32'h140, 1'b1, 1'b1, 32'h2000, 1'b1);

        // Flush concurrent with taken BR: ghr e -> d, BTB/RAS cleared
        upd(32'h800, BP_JAL, 1'b1, 1'b1, 32'h1000, 4'hf, 1'b0);
        upd(32'h13C, BP_BR, 1'b0, 1'b0, 32'h200, 4'hf, 1'b0);
        upd(32'h104, BP_BR, 1'b0, 1'b1, 32'h300, 4'he, 1'b1);
        lk("flush_800", 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
        lk("flush_140", 32'h140, 1'b0, 1'b0, 32'h0, 1'b0);
        lk("flush_104", 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
        lk("flush_704", 32'h704, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("flush.ghr", 32'(bus.if_ghr_o), 32'hd);
        upd(32'h704, BP_RET, 1'b0, 1'b1, 32'h900, 4'hd, 1'b0);
        lk("flush_ras", 32'h704, 1'b1, 1'b1, 32'h900, 1'b1);

        // Async reset mid-cycle with an update pending
        bus.if_pc_i      = 32'h704;
        bus.ex_valid_i   = 1'b1;
        bus.ex_pc_i      = 32'h704;
        bus.ex_type_i    = BP_JAL;
        bus.ex_is_call_i = 1'b1;
        bus.ex_taken_i   = 1'b1;
        bus.ex_target_i  = 32'h3000;
        #2 rst = 1'b0;
        #1;
        chk("arst.hit", 32'(bus.if_hit_o), 32'h0);
        chk("arst.taken", 32'(bus.if_taken_o), 32'h0);
        chk("arst.target", bus.if_target_o, 32'h0);
        chk("arst.ghr", 32'(bus.if_ghr_o), 32'h0);
        @(posedge clk);
        #1;
        bus.ex_valid_i   = 1'b0;
        bus.ex_is_call_i = 1'b0;
        rst = 1'b1;
        lk("post_arst", 32'h704, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_prediction_unit.md
# branch_prediction_unit

Parametrised front-end predictor for the 5-stage RV32 pipeline, replacing the fixed 16-entry BTB and 4-bit global predictor pair. Provides a same-cycle IF-stage prediction (hit, taken, target, history snapshot) from a direct-mapped typed BTB, a gshare PHT and a return-address stack. All state is updated non-speculatively from resolved control-flow instructions in EX.

## Interface
- XLEN, 32, address/data width
- BTB_ENTRIES, 16, BTB entries (power of 2, ≥2)
- GHR_W, 4, global history bits; PHT has 2^GHR_W two-bit counters
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_pc_i  in  XLEN  fetch PC
- if_hit_o  out  1  BTB valid+tag match
- if_taken_o  out  1  predicted redirect
- if_target_o  out  XLEN  predicted target
- if_ghr_o  out  GHR_W  history snapshot, carried down pipe
- ex_valid_i  in  1  resolved control-flow op in EX this cycle (caller qualifies with stall/wait)
- ex_pc_i  in  XLEN  EX PC
- ex_type_i  in  2  bp_type_e of EX op
- ex_is_call_i  in  1  JAL/JALR writing x1/x5
- ex_taken_i  in  1  actual outcome (1 for jumps)
- ex_target_i  in  XLEN  actual target
- ex_ghr_i  in  GHR_W  snapshot taken at prediction
- flush_i  in  1  invalidate BTB and empty RAS (fence.i)

## Operation
- BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[XLEN-1:log2(BTB_ENTRIES)+2]. Entry: valid, tag, target, type.
- PHT index = pc[GHR_W+1:2] XOR ghr; counters 0..3, taken when bit1 = 1; saturating.
- Prediction (combinational): if_hit_o = valid && tag match. if_taken_o = hit && (type≠BR || PHT[idx][1]). Target: type RET and RAS non-empty → RAS top; else BTB target. if_ghr_o = current ghr.
- Update when ex_valid_i:
  - BR: PHT[ex_pc[GHR_W+1:2]^ex_ghr_i] ± 1 saturating; ghr ← {ghr[GHR_W-2:0], ex_taken_i}. BTB written only if taken.
  - JAL/JALR/RET: BTB written (valid, tag, ex_target_i, ex_type_i). PHT/ghr untouched.
  - ex_is_call_i: push ex_pc_i+4. type RET: pop. Call and RET on same op (jalr x1,x1): pop then push (top replaced).
- RAS circular: push when full overwrites oldest, count saturates at RAS_DEPTH; pop when empty is no-op, count stays 0.
- flush_i: all BTB valid ← 0, RAS count ← 0, same cycle. Concurrent ex update: PHT/ghr still applied; BTB and RAS writes dropped.
- ex_valid_i low: no state change.

## Timing
- Prediction: 0-cycle combinational from if_pc_i and registered state.
- Updates visible to lookup the cycle after the ex_valid_i edge; same-cycle write to the index being looked up returns the old entry.
- Reset (async, rst low): BTB valid all 0, PHT all 2'b01, ghr 0, RAS pointer/count 0. Outputs during/after reset: if_hit_o 0, if_taken_o 0, if_target_o = 0 (invalid entry target reset to 0), if_ghr_o 0.
- Reset mid-update: state forced to reset values immediately; no partial write survives.

## Structure
- Package bp_pkg: bp_type_e (BP_BR=0, BP_JAL=1, BP_JALR=2, BP_RET=3), counter constants (PHT_RESET=2'b01, PHT_MAX=2'b11), btb_entry_t struct.
- Sub-module bp_ras: push/pop/flush, top output, empty flag, parametrised by XLEN and RAS_DEPTH.

## Test plan
- Reset, if_pc_i=0x100 → if_hit_o 0, if_taken_o 0, if_ghr_o 0.
- BR at 0x100 taken to 0x80 three times (ex_ghr_i tracking) → counter reaches 3, next lookup of 0x100 with matching ghr gives hit 1, taken 1, target 0x80; one not-taken → counter 2, still taken.
- Calls at 0x200,0x300,0x400,0x500,0x600 (RAS_DEPTH=4) → RAS holds 0x604,0x504,0x404,0x304; RET lookup targets 0x604; five pops → 0x504..0x304 then RAS empty, RET falls back to BTB target.
- Aliasing: 0x100 and 0x100+4·BTB_ENTRIES → second write evicts first; lookup of 0x100 misses.
- flush_i with concurrent taken BR update → BTB all invalid, RAS empty, ghr still shifted by 1.
- Async rst asserted mid-stream between clock edges → outputs at reset values before next edge.
